vga_line_buffer: RTL and testbench



---
 rtl/vga_line_buffer_if.sv | 30 +++
 rtl/vga_line_buffer.sv | 105 ++++++++++
 tb/tb_vga_line_buffer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_line_buffer_if.sv
// Bundle of the VGA-side request/pixel port and the SDRAM-side row fetch stream
// for vga_line_buffer.
interface vga_line_buffer_if #(
  parameter int unsigned COLOR_W = 15,
  parameter int unsigned ROW_W   = 9
);
  logic               r_req;
  logic [ROW_W-1:0]   y_next;
  logic [8:0]         x_next;
  logic [COLOR_W-1:0] color;
  logic               fetch_req;
  logic [ROW_W-1:0]   fetch_row;
  logic               fetch_ack;
  logic               fetch_valid;
  logic [COLOR_W-1:0] fetch_data;
  logic               line_done;
  logic               late_err;
  logic               overrun_err;
  logic               err_clr;

  modport master (
    output r_req, y_next, x_next, fetch_ack, fetch_valid, fetch_data, err_clr,
    input  color, fetch_req, fetch_row, line_done, late_err, overrun_err
  );

  modport slave (
    input  r_req, y_next, x_next, fetch_ack, fetch_valid, fetch_data, err_clr,
    output color, fetch_req, fetch_row, line_done, late_err, overrun_err
  );
endinterface

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer: fetches the next display row into the back bank while the
// front bank serves pixels combinationally to the VGA controller.
module vga_line_buffer #(
  parameter int unsigned LINE_W  = 512,
  parameter int unsigned COLOR_W = 15,
  parameter int unsigned ROW_W   = 9
) (
  input logic            clk,
  input logic            reset,
  vga_line_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(LINE_W);

  typedef enum logic [1:0] {StIdle, StReq, StRecv, StDone} state_e;

  state_e             state_q, state_d;
  logic               front_q, front_d;
  logic               r_req_q;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ROW_W-1:0]   fetch_row_q, fetch_row_d;
  logic               line_done_q, line_done_d;
  logic               late_q, late_d;
  logic               ovr_q, ovr_d;
  logic               late_set, ovr_set;
  logic               we;
  logic               start;

  logic [COLOR_W-1:0] bank [2][LINE_W];

  assign start = bus.r_req & ~r_req_q;

  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    wr_ptr_d    = wr_ptr_q;
    fetch_row_d = fetch_row_q;
    line_done_d = 1'b0;
    late_set    = 1'b0;
    ovr_set     = 1'b0;
    we          = 1'b0;
    if (start) begin
      // A start wins over same-cycle ack/valid; that word is silently discarded.
      front_d     = ~front_q;
      fetch_row_d = bus.y_next;
      wr_ptr_d    = '0;
      state_d     = StReq;
      late_set    = (state_q == StReq) || (state_q == StRecv);
    end else begin
      unique case (state_q)
        StIdle, StDone: ovr_set = bus.fetch_valid;
        StReq: begin
          ovr_set = bus.fetch_valid;
          if (bus.fetch_ack) state_d = StRecv;
        end
        StRecv: begin
          if (bus.fetch_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == AW'(LINE_W - 1)) begin
              state_d     = StDone;
              line_done_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    late_d = late_set | (late_q & ~bus.err_clr);
    ovr_d  = ovr_set | (ovr_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      front_q     <= 1'b0;
      r_req_q     <= 1'b0;
      wr_ptr_q    <= '0;
      fetch_row_q <= '0;
      line_done_q <= 1'b0;
      late_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      r_req_q     <= bus.r_req;
      wr_ptr_q    <= wr_ptr_d;
      fetch_row_q <= fetch_row_d;
      line_done_q <= line_done_d;
      late_q      <= late_d;
      ovr_q       <= ovr_d;
    end
  end

  // Storage is not reset; writes always target the back bank.
  always_ff @(posedge clk) begin
    if (we) bank[~front_q][wr_ptr_q] <= bus.fetch_data;
  end

  assign bus.color       = bank[front_q][bus.x_next[AW-1:0]];
  assign bus.fetch_req   = (state_q == StReq);
  assign bus.fetch_row   = fetch_row_q;
  assign bus.line_done   = line_done_q;
  assign bus.late_err    = late_q;
  assign bus.overrun_err = ovr_q;
endmodule

// File: tb/tb_vga_line_buffer.sv
// Directed self-checking bench for vga_line_buffer: fetch handshake, bank swapping,
// late/overrun flags and asynchronous reset.
module tb_vga_line_buffer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  vga_line_buffer_if #(.COLOR_W(15), .ROW_W(9)) bus ();

  vga_line_buffer #(.LINE_W(512), .COLOR_W(15), .ROW_W(9)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  localparam logic [14:0] PatA = 15'h0000;
  localparam logic [14:0] PatB = 15'h4000;
  localparam logic [14:0] PatC = 15'h2000;
  localparam logic [14:0] PatD = 15'h1000;
  localparam logic [14:0] PatE = 15'h0800;
  localparam logic [14:0] PatF = 15'h6000;

  function automatic logic [14:0] pat(input logic [14:0] base, input int x);
    return base | 15'(x);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_rise(input logic [8:0] row);
    bus.r_req  = 1'b1;
    bus.y_next = row;
    step();
  endtask

  task automatic req_fall();
    bus.y_next = 9'h1ff;
    step();
    bus.r_req = 1'b0;
  endtask

  task automatic do_ack();
    bus.fetch_ack = 1'b1;
    step();
    bus.fetch_ack = 1'b0;
  endtask

  // Streams n words base|x; counts line_done pulses and samples line_done after the last word.
  task automatic send_words(input int n, input logic [14:0] base, input bit gaps,
                            output int pulses, output logic ld_last);
    pulses  = 0;
    ld_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_data  = pat(base, i);
      step();
      bus.fetch_valid = 1'b0;
      if (bus.line_done) pulses++;
      if (i == n - 1) ld_last = bus.line_done;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          step();
          if (bus.line_done) pulses++;
        end
      end
    end
    repeat (3) begin
      step();
      if (bus.line_done) pulses++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++; if (bus.fetch_req !== 1'b0) $display("FAIL rst_fetch_req got %b want 0", bus.fetch_req); else passed++;
    checks++; if (bus.fetch_row !== 9'd0) $display("FAIL rst_fetch_row got %h want 0", bus.fetch_row); else passed++;
    checks++; if (bus.line_done !== 1'b0) $display("FAIL rst_line_done got %b want 0", bus.line_done); else passed++;
    checks++; if (bus.late_err !== 1'b0) $display("FAIL rst_late_err got %b want 0", bus.late_err); else passed++;
    checks++; if (bus.overrun_err !== 1'b0) $display("FAIL rst_overrun got %b want 0", bus.overrun_err); else passed++;
    reset = 1'b0;
    step();
    // Valid word while idle is an overrun.
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 15'h7fff;
    step();
    bus.fetch_valid = 1'b0;
    checks++; if (bus.overrun_err !== 1'b1) $display("FAIL idle_overrun got %b want 1", bus.overrun_err); else passed++;
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    checks++; if (bus.overrun_err !== 1'b0) $display("FAIL idle_clr got %b want 0", bus.overrun_err); else passed++;
  endtask

  task automatic test_back_to_back();
    int   p;
    logic ld;
    req_rise(9'h05);
    checks++; if (bus.fetch_req !== 1'b1) $display("FAIL start_req got %b want 1", bus.fetch_req); else passed++;
    checks++; if (bus.fetch_row !== 9'h05) $display("FAIL start_row got %h want 005", bus.fetch_row); else passed++;
    req_fall();
    checks++; if (bus.fetch_row !== 9'h05) $display("FAIL second_high_row got %h want 005", bus.fetch_row); else passed++;
    checks++; if (bus.late_err !== 1'b0) $display("FAIL second_high_late got %b want 0", bus.late_err); else passed++;
    do_ack();
    checks++; if (bus.fetch_req !== 1'b0) $display("FAIL ack_drop got %b want 0", bus.fetch_req); else passed++;
    send_words(512, PatA, 1'b0, p, ld);
    checks++; if (p !== 1) $display("FAIL b2b_pulses got %0d want 1", p); else passed++;
    checks++; if (ld !== 1'b1) $display("FAIL b2b_pulse_time got %b want 1", ld); else passed++;
  endtask

  task automatic test_swap_gaps();
    int p;
    req_rise(9'h06);
    checks++; if (bus.fetch_row !== 9'h06) $display("FAIL swap_row got %h want 006", bus.fetch_row); else passed++;
    req_fall();
    for (int x = 0; x < 512; x++) begin
      bus.x_next = 9'(x);
      #1;
      checks++; if (bus.color !== pat(PatA, x)) $display("FAIL showA x=%0d got %h want %h", x, bus.color, pat(PatA, x)); else passed++;
    end
    do_ack();
    // Fill the back bank with gaps while the front bank keeps showing A.
    p = 0;
    for (int i = 0; i < 512; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_data  = pat(PatB, i);
      bus.x_next      = 9'((i * 37) % 512);
      #1;
      checks++; if (bus.color !== pat(PatA, (i * 37) % 512)) $display("FAIL holdA i=%0d got %h want %h", i, bus.color, pat(PatA, (i * 37) % 512)); else passed++;
      step();
      bus.fetch_valid = 1'b0;
      if (bus.line_done) p++;
      repeat ($urandom_range(0, 2)) begin
        step();
        if (bus.line_done) p++;
      end
    end
    repeat (3) begin
      step();
      if (bus.line_done) p++;
    end
    checks++; if (p !== 1) $display("FAIL gaps_pulses got %0d want 1", p); else passed++;
    req_rise(9'h07);
    req_fall();
    for (int x = 0; x < 512; x++) begin
      bus.x_next = 9'(x);
      #1;
      checks++; if (bus.color !== pat(PatB, x)) $display("FAIL showB x=%0d got %h want %h", x, bus.color, pat(PatB, x)); else passed++;
    end
  endtask

  task automatic test_late();
    int   p;
    logic ld;
    do_ack();
    send_words(300, PatC, 1'b0, p, ld);
    checks++; if (p !== 0) $display("FAIL partial_pulses got %0d want 0", p); else passed++;
    req_rise(9'h08);
    checks++; if (bus.late_err !== 1'b1) $display("FAIL late_set got %b want 1", bus.late_err); else passed++;
    checks++; if (bus.fetch_req !== 1'b1) $display("FAIL late_req got %b want 1", bus.fetch_req); else passed++;
    checks++; if (bus.fetch_row !== 9'h08) $display("FAIL late_row got %h want 008", bus.fetch_row); else passed++;
    req_fall();
    for (int x = 0; x < 512; x++) begin
      bus.x_next = 9'(x);
      #1;
      checks++; if (bus.color !== ((x < 300) ? pat(PatC, x) : pat(PatA, x))) $display("FAIL stale x=%0d got %h want %h", x, bus.color, (x < 300) ? pat(PatC, x) : pat(PatA, x)); else passed++;
    end
  endtask

  task automatic test_overrun();
    int   p;
    logic ld;
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    checks++; if (bus.late_err !== 1'b0) $display("FAIL late_clr got %b want 0", bus.late_err); else passed++;
    // Word in the ack cycle is still in REQ: dropped and flagged.
    bus.fetch_ack   = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 15'h7fff;
    step();
    bus.fetch_ack   = 1'b0;
    bus.fetch_valid = 1'b0;
    checks++; if (bus.overrun_err !== 1'b1) $display("FAIL ack_overrun got %b want 1", bus.overrun_err); else passed++;
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    checks++; if (bus.overrun_err !== 1'b0) $display("FAIL ovr_clr got %b want 0", bus.overrun_err); else passed++;
    send_words(512, PatD, 1'b0, p, ld);
    checks++; if (p !== 1) $display("FAIL d_pulses got %0d want 1", p); else passed++;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 15'h7fff;
    step();
    checks++; if (bus.overrun_err !== 1'b1) $display("FAIL done_overrun got %b want 1", bus.overrun_err); else passed++;
    bus.err_clr = 1'b1;
    step();
    bus.fetch_valid = 1'b0;
    checks++; if (bus.overrun_err !== 1'b1) $display("FAIL set_wins got %b want 1", bus.overrun_err); else passed++;
    step();
    bus.err_clr = 1'b0;
    checks++; if (bus.overrun_err !== 1'b0) $display("FAIL clr_after got %b want 0", bus.overrun_err); else passed++;
    // Valid coinciding with start is discarded without an overrun.
    bus.fetch_valid = 1'b1;
    req_rise(9'h09);
    bus.fetch_valid = 1'b0;
    checks++; if (bus.overrun_err !== 1'b0) $display("FAIL start_prio got %b want 0", bus.overrun_err); else passed++;
    checks++; if (bus.late_err !== 1'b0) $display("FAIL ontime_late got %b want 0", bus.late_err); else passed++;
    req_fall();
    for (int x = 0; x < 512; x++) begin
      bus.x_next = 9'(x);
      #1;
      checks++; if (bus.color !== pat(PatD, x)) $display("FAIL showD x=%0d got %h want %h", x, bus.color, pat(PatD, x)); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int   p;
    logic ld;
    do_ack();
    send_words(100, PatE, 1'b0, p, ld);
    reset = 1'b1;
    #1;
    checks++; if (bus.fetch_req !== 1'b0) $display("FAIL mid_req got %b want 0", bus.fetch_req); else passed++;
    checks++; if (bus.fetch_row !== 9'd0) $display("FAIL mid_row got %h want 0", bus.fetch_row); else passed++;
    bus.x_next = 9'd50;
    #1;
    checks++; if (bus.color !== pat(PatE, 50)) $display("FAIL mid_col50 got %h want %h", bus.color, pat(PatE, 50)); else passed++;
    bus.x_next = 9'd400;
    #1;
    checks++; if (bus.color !== pat(PatA, 400)) $display("FAIL mid_col400 got %h want %h", bus.color, pat(PatA, 400)); else passed++;
    step();
    reset = 1'b0;
    step();
    req_rise(9'h0a);
    checks++; if (bus.fetch_req !== 1'b1) $display("FAIL post_req got %b want 1", bus.fetch_req); else passed++;
    checks++; if (bus.fetch_row !== 9'h0a) $display("FAIL post_row got %h want 00a", bus.fetch_row); else passed++;
    req_fall();
    do_ack();
    send_words(512, PatF, 1'b0, p, ld);
    checks++; if (p !== 1) $display("FAIL f_pulses got %0d want 1", p); else passed++;
    req_rise(9'h0b);
    req_fall();
    for (int x = 0; x < 512; x++) begin
      bus.x_next = 9'(x);
      #1;
      checks++; if (bus.color !== pat(PatF, x)) $display("FAIL showF x=%0d got %h want %h", x, bus.color, pat(PatF, x)); else passed++;
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.r_req       = 1'b0;
    bus.y_next      = '0;
    bus.x_next      = '0;
    bus.fetch_ack   = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = '0;
    bus.err_clr     = 1'b0;
    test_reset();
    test_back_to_back();
    test_swap_gaps();
    test_late();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
